// File: rtl/time_uart_tx.sv
// time_uart_tx -- sends the current time of day as "HH:MM:SS" plus a line
// terminator over a UART line (8N1, LSB first) once per accepted TRIG.
//
// Ports:
//   CLK            system clock, rising edge
//   RST            asynchronous active-low reset
//   TRIG           one-cycle send request (1 Hz tick)
//   SEC1/MIN1/HOUR1        BCD units digits (4 bits)
//   SEC10/MIN10 (3 bits), HOUR10 (2 bits)  BCD tens digits
//   TXD            serial data, idle high (registered)
//   BUSY           high while a frame is being sent (registered)
//   OVR            one-cycle pulse when TRIG arrives during a frame (registered)
//
// Parameters: CLK_FREQ, BAUD; one bit lasts BAUD_DIV = CLK_FREQ/BAUD clocks
// (must be >= 2).
//
// Configuration macro TIMETX_CRLF_EN:
//   defined   -> terminator is CR LF (10 bytes per frame)
//   undefined -> terminator is LF only (9 bytes per frame)

module time_uart_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TRIG,
  input  logic [3:0] SEC1,
  input  logic [2:0] SEC10,
  input  logic [3:0] MIN1,
  input  logic [2:0] MIN10,
  input  logic [3:0] HOUR1,
  input  logic [1:0] HOUR10,
  output logic       TXD,
  output logic       BUSY,
  output logic       OVR
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

`ifdef TIMETX_CRLF_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd8;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_cnt_r;
  logic [3:0]       byte_idx_r;
  logic [3:0]       sec1_r, sec10_r, min1_r, min10_r, hour1_r, hour10_r;
  logic             txd_r;
  logic             busy_r;
  logic             ovr_r;

  logic [7:0]       cur_byte_s;
  logic [2:0]       next_bit_s;

  // BCD digit to ASCII; anything outside 0..9 is shown as '?'.
  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    logic [7:0] a;
    if (d <= 4'd9) begin
      a = 8'h30 + {4'h0, d};
    end else begin
      a = 8'h3F;
    end
    return a;
  endfunction

  // Select the byte currently being serialised from the snapshot.
  always_comb begin
    cur_byte_s = 8'hFF;
    next_bit_s = bit_cnt_r + 3'd1;
    case (byte_idx_r)
      4'd0:    cur_byte_s = digit_ascii(hour10_r);
      4'd1:    cur_byte_s = digit_ascii(hour1_r);
      4'd2:    cur_byte_s = 8'h3A;
      4'd3:    cur_byte_s = digit_ascii(min10_r);
      4'd4:    cur_byte_s = digit_ascii(min1_r);
      4'd5:    cur_byte_s = 8'h3A;
      4'd6:    cur_byte_s = digit_ascii(sec10_r);
      4'd7:    cur_byte_s = digit_ascii(sec1_r);
`ifdef TIMETX_CRLF_EN
      4'd8:    cur_byte_s = 8'h0D;
      4'd9:    cur_byte_s = 8'h0A;
`else
      4'd8:    cur_byte_s = 8'h0A;
`endif
      default: cur_byte_s = 8'hFF;
    endcase
  end

  // Transmit FSM: every output is registered and set on the edge that
  // enters the corresponding bit, so TXD changes exactly on bit boundaries.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= IDLE;
      baud_cnt_r <= '0;
      bit_cnt_r  <= 3'd0;
      byte_idx_r <= 4'd0;
      sec1_r     <= 4'd0;
      sec10_r    <= 4'd0;
      min1_r     <= 4'd0;
      min10_r    <= 4'd0;
      hour1_r    <= 4'd0;
      hour10_r   <= 4'd0;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
      ovr_r      <= 1'b0;
    end else begin
      // busy_r mirrors "state != IDLE", including the edge BUSY falls on,
      // so a TRIG on that edge is reported as an overrun, not accepted.
      ovr_r <= TRIG & busy_r;
      case (state_r)
        IDLE: begin
          txd_r  <= 1'b1;
          busy_r <= 1'b0;
          if (TRIG) begin
            sec1_r     <= SEC1;
            sec10_r    <= {1'b0, SEC10};
            min1_r     <= MIN1;
            min10_r    <= {1'b0, MIN10};
            hour1_r    <= HOUR1;
            hour10_r   <= {2'b00, HOUR10};
            state_r    <= START;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            byte_idx_r <= 4'd0;
            txd_r      <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        START: begin
          if (baud_cnt_r == CNT_LAST) begin
            state_r    <= DATA;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            txd_r      <= cur_byte_s[0];
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt_r == CNT_LAST) begin
            baud_cnt_r <= '0;
            if (bit_cnt_r == 3'd7) begin
              state_r   <= STOP;
              bit_cnt_r <= 3'd0;
              txd_r     <= 1'b1;
            end else begin
              bit_cnt_r <= next_bit_s;
              txd_r     <= cur_byte_s[next_bit_s];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt_r == CNT_LAST) begin
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            if (byte_idx_r == LAST_IDX) begin
              state_r    <= IDLE;
              byte_idx_r <= 4'd0;
              txd_r      <= 1'b1;
              busy_r     <= 1'b0;
            end else begin
              // Next start bit follows the stop bit with no idle gap.
              state_r    <= START;
              byte_idx_r <= byte_idx_r + 4'd1;
              txd_r      <= 1'b0;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          baud_cnt_r <= '0;
          bit_cnt_r  <= 3'd0;
          byte_idx_r <= 4'd0;
          txd_r      <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign TXD  = txd_r;
  assign BUSY = busy_r;
  assign OVR  = ovr_r;

endmodule

// File: tb/tb_time_uart_tx.sv
// Self-checking bench for time_uart_tx (CLK_FREQ=16, BAUD=1 -> 16 clocks/bit).
// A UART receiver decodes TXD independently; frame contents, BUSY length,
// overrun pulses and reset behaviour are compared with hand-computed values.
// Honours TIMETX_CRLF_EN the same way the design does.

module tb_time_uart_tx;

  localparam int DIV = 16;
`ifdef TIMETX_CRLF_EN
  localparam int NBYTES = 10;
`else
  localparam int NBYTES = 9;
`endif
  localparam int FRAME_CLKS = NBYTES * 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       trig = 1'b0;
  logic [3:0] sec1 = 4'd0, min1 = 4'd0, hour1 = 4'd0;
  logic [2:0] sec10 = 3'd0, min10 = 3'd0;
  logic [1:0] hour10 = 2'd0;
  logic       txd, busy, ovr;

  time_uart_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .CLK(clk), .RST(rst), .TRIG(trig),
    .SEC1(sec1), .SEC10(sec10), .MIN1(min1), .MIN10(min10),
    .HOUR1(hour1), .HOUR10(hour10),
    .TXD(txd), .BUSY(busy), .OVR(ovr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Receiver state
  logic [7:0] rx_q[$];
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_shift = 8'h00;
  int         rx_err = 0;

  // BUSY / OVR observation
  logic busy_prev = 1'b0;
  int   busy_run = 0;
  int   last_busy = 0;
  int   frames = 0;
  int   ovr_cycles = 0;

  typedef struct {
    logic [1:0]  h10;
    logic [3:0]  h1;
    logic [2:0]  m10;
    logic [3:0]  m1;
    logic [2:0]  s10;
    logic [3:0]  s1;
    logic [63:0] body;   // expected "HH:MM:SS" bytes, first byte in MSBs
  } vec_t;

  vec_t vecs[5];

  // UART receiver sampling mid-bit on falling clock edges.
  always @(negedge clk) begin
    if (!rst) begin
      rx_active <= 1'b0;
      rx_cnt    <= 0;
    end else if (!rx_active) begin
      if (txd == 1'b0) begin
        rx_active <= 1'b1;
        rx_cnt    <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if ((rx_cnt % DIV) == DIV / 2) begin
        if (rx_cnt / DIV == 0) begin
          if (txd !== 1'b0) rx_err <= rx_err + 1;
        end else if (rx_cnt / DIV <= 8) begin
          rx_shift[rx_cnt / DIV - 1] <= txd;
        end else begin
          if (txd !== 1'b1) rx_err <= rx_err + 1;
          rx_q.push_back(rx_shift);
          rx_active <= 1'b0;
        end
      end
    end
  end

  // BUSY run length, frame starts and OVR cycles.
  always @(negedge clk) begin
    busy_prev <= busy;
    if (busy) begin
      busy_run <= busy_run + 1;
    end else if (busy_run != 0) begin
      last_busy <= busy_run;
      busy_run  <= 0;
    end
    if (busy && !busy_prev) frames <= frames + 1;
    if (ovr) ovr_cycles <= ovr_cycles + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [63:0] body, input int i);
    logic [7:0] b;
    if (i < 8) begin
      b = body[63 - 8 * i -: 8];
`ifdef TIMETX_CRLF_EN
    end else if (i == 8) begin
      b = 8'h0D;
`endif
    end else begin
      b = 8'h0A;
    end
    return b;
  endfunction

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < FRAME_CLKS + 64; c++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    check({name, " busy_fall_timeout"}, {31'd0, done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_bytes(input string name, input logic [63:0] body, input int nframes);
    check({name, " byte_count"}, rx_q.size(), nframes * NBYTES);
    for (int i = 0; i < nframes * NBYTES; i++) begin
      check($sformatf("%s byte%0d", name, i),
            (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD,
            {24'd0, exp_byte(body, i % NBYTES)});
    end
  endtask

  // One complete frame: optional reset release on the trigger edge and an
  // optional SEC1 change one cycle after the trigger.
  task automatic run_frame(input string name, input vec_t v, input bit release_rst, input int new_s1);
    int ovr0, frames0, err0;
    @(negedge clk);
    hour10 = v.h10; hour1 = v.h1; min10 = v.m10; min1 = v.m1; sec10 = v.s10; sec1 = v.s1;
    rx_q.delete();
    ovr0 = ovr_cycles; frames0 = frames; err0 = rx_err;
    trig = 1'b1;
    if (release_rst) rst = 1'b1;
    @(posedge clk); #1;
    check({name, " txd_after_trig"}, {31'd0, txd}, 32'd0);
    check({name, " busy_after_trig"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    trig = 1'b0;
    if (new_s1 >= 0) sec1 = new_s1[3:0];
    wait_idle(name);
    check({name, " busy_len"}, last_busy, FRAME_CLKS);
    check_bytes(name, v.body, 1);
    check({name, " framing"}, rx_err - err0, 0);
    check({name, " ovr_none"}, ovr_cycles - ovr0, 0);
    check({name, " one_frame"}, frames - frames0, 1);
    check({name, " txd_idle"}, {31'd0, txd}, 32'd1);
  endtask

  initial begin
    int ovr0, frames0;
    vec_t v;

    vecs[0] = '{h10: 2'd2, h1: 4'd3, m10: 3'd5, m1: 4'd9, s10: 3'd5, s1: 4'd8, body: 64'h32333A35_393A3538};
    vecs[1] = '{h10: 2'd0, h1: 4'd0, m10: 3'd0, m1: 4'd0, s10: 3'd0, s1: 4'd0, body: 64'h30303A30_303A3030};
    vecs[2] = '{h10: 2'd1, h1: 4'hA, m10: 3'd0, m1: 4'd7, s10: 3'd4, s1: 4'd2, body: 64'h313F3A30_373A3432};
    vecs[3] = '{h10: 2'd3, h1: 4'hF, m10: 3'd7, m1: 4'd9, s10: 3'd7, s1: 4'hF, body: 64'h333F3A37_393A373F};
    vecs[4] = '{h10: 2'd1, h1: 4'd9, m10: 3'd4, m1: 4'd5, s10: 3'd0, s1: 4'd1, body: 64'h31393A34_353A3031};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset txd", {31'd0, txd}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset ovr", {31'd0, ovr}, 32'd0);

    // Table: first entry also releases reset on the trigger edge.
    for (int k = 0; k < 5; k++) begin
      run_frame($sformatf("vec%0d", k), vecs[k], (k == 0), -1);
    end

    // Snapshot: SEC1 changes 8 -> 9 one cycle after TRIG.
    run_frame("snapshot", vecs[0], 1'b0, 9);

    // Overrun sequence: TRIG 100 clocks in and on the BUSY-falling edge,
    // then a TRIG on the following edge starts a new frame.
    v = '{h10: 2'd1, h1: 4'd2, m10: 3'd3, m1: 4'd4, s10: 3'd5, s1: 4'd6, body: 64'h31323A33_343A3536};
    @(negedge clk);
    hour10 = v.h10; hour1 = v.h1; min10 = v.m10; min1 = v.m1; sec10 = v.s10; sec1 = v.s1;
    rx_q.delete();
    ovr0 = ovr_cycles; frames0 = frames;
    trig = 1'b1;
    @(posedge clk); #1;
    check("ovr_seq busy_start", {31'd0, busy}, 32'd1);
    @(negedge clk);
    trig = 1'b0;
    repeat (99) @(negedge clk);
    trig = 1'b1;
    @(posedge clk); #1;
    check("ovr_seq mid_ovr", {31'd0, ovr}, 32'd1);
    @(negedge clk);
    trig = 1'b0;
    @(posedge clk); #1;
    check("ovr_seq mid_ovr_clear", {31'd0, ovr}, 32'd0);
    check("ovr_seq mid_busy", {31'd0, busy}, 32'd1);
    repeat (FRAME_CLKS - 101) @(negedge clk);
    trig = 1'b1;
    @(posedge clk); #1;
    check("ovr_seq fall_busy", {31'd0, busy}, 32'd0);
    check("ovr_seq fall_ovr", {31'd0, ovr}, 32'd1);
    @(negedge clk);
    @(posedge clk); #1;
    check("ovr_seq next_busy", {31'd0, busy}, 32'd1);
    check("ovr_seq next_ovr", {31'd0, ovr}, 32'd0);
    @(negedge clk);
    trig = 1'b0;
    wait_idle("ovr_seq");
    check("ovr_seq ovr_cycles", ovr_cycles - ovr0, 2);
    check("ovr_seq frames", frames - frames0, 2);
    check_bytes("ovr_seq", v.body, 2);

    // Reset 500 clocks into a frame, then a clean frame after release.
    @(negedge clk);
    hour10 = 2'd2; hour1 = 4'd3; min10 = 3'd5; min1 = 4'd9; sec10 = 3'd5; sec1 = 4'd8;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    repeat (499) @(negedge clk);
    check("abort busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort txd", {31'd0, txd}, 32'd1);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort ovr", {31'd0, ovr}, 32'd0);
    repeat (20) @(negedge clk);
    check("abort txd_held", {31'd0, txd}, 32'd1);
    run_frame("after_abort", vecs[0], 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
